// File: rtl/cmp_config_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmp_config_loader_pkg
// Description : Values shared by the configuration loader and the comparator.
//               These include the hash capacity, the derived index/count MSBs
//               and the packet terminator byte. The package also holds the
//               loader FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cmp_config_loader_pkg;

  // Comparator capacity in 32-bit hashes. This must be a power of two in the
  // range 2..4096.
  localparam int NUM_HASHES     = 512;
  localparam int HASH_NUM_MSB   = $clog2(NUM_HASHES) - 1;
  localparam int HASH_COUNT_MSB = $clog2(NUM_HASHES);

  // Terminator byte that closes every configuration packet.
  localparam logic [7:0] CMP_CONFIG_MAGIC = 8'hCC;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_MAGIC  = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

endpackage : cmp_config_loader_pkg
`default_nettype wire

// File: rtl/cmp_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : cmp_config_loader
// Description : Parses the comparator configuration packet from a FWFT byte
//               FIFO. The packet format is: cnt_lo, cnt_hi, N*4 hash bytes,
//               then MAGIC. The module loads the comparator hash memory and
//               hash count. Consumption pauses while the comparator is busy.
//               A malformed packet sets a sticky error flag.
// Ports       : CLK, rst         - clock, async active-high reset
//               din/empty/rd_en  - FWFT FIFO read side (rd_en combinational)
//               cmp_busy         - comparator busy; no bytes accepted while 1
//               dout/wr_en/wr_addr - byte write into comparator memory
//               hash_count       - number of valid hashes
//               config_valid     - comparator holds a complete configuration
//               error            - sticky malformed-packet flag
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_config_loader #(
  parameter int         NUM_HASHES     = cmp_config_loader_pkg::NUM_HASHES,
  parameter int         HASH_NUM_MSB   = $clog2(NUM_HASHES) - 1,
  parameter int         HASH_COUNT_MSB = $clog2(NUM_HASHES),
  parameter logic [7:0] MAGIC          = cmp_config_loader_pkg::CMP_CONFIG_MAGIC
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic [7:0]              din,
  input  logic                    empty,
  output logic                    rd_en,
  input  logic                    cmp_busy,
  output logic [7:0]              dout,
  output logic                    wr_en,
  output logic [HASH_NUM_MSB+2:0] wr_addr,
  output logic [HASH_COUNT_MSB:0] hash_count,
  output logic                    config_valid,
  output logic                    error
);

  import cmp_config_loader_pkg::*;

  localparam int          AW      = HASH_NUM_MSB + 3;   // byte address width
  localparam int          CW      = HASH_COUNT_MSB + 1; // hash count width
  localparam logic [15:0] C_MAX_N = 16'(NUM_HASHES);

  state_t          state_q, state_d;
  logic [7:0]      cnt_lo_q, cnt_lo_d;
  logic [CW-1:0]   n_q, n_d;
  logic [AW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]      dout_q, dout_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [CW-1:0]   hash_count_q, hash_count_d;
  logic            config_valid_q, config_valid_d;
  logic            error_q, error_d;

  logic [15:0]     w_n_raw;
  logic            w_n_bad;
  logic [AW-1:0]   w_last;

  // Byte acceptance is purely combinational so a FWFT FIFO pops on the
  // same edge at which the FSM samples din.
  assign rd_en = !empty && !cmp_busy &&
                 (state_q inside {ST_IDLE, ST_CNT_HI, ST_DATA, ST_MAGIC});

  assign w_n_raw = {din, cnt_lo_q};
  assign w_n_bad = (w_n_raw == 16'd0) || (w_n_raw > C_MAX_N);

  // The last byte address is N*4-1, computed modulo 2^AW. When N equals
  // NUM_HASHES, the top count bit drops out. The subtraction then wraps to
  // all-ones, which is the correct final address.
  assign w_last = {n_q[CW-2:0], 2'b00} - AW'(1);

  always_comb begin
    state_d        = state_q;
    cnt_lo_d       = cnt_lo_q;
    n_d            = n_q;
    byte_cnt_d     = byte_cnt_q;
    dout_d         = dout_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    hash_count_d   = hash_count_q;
    config_valid_d = config_valid_q;
    error_d        = error_q;

    case (state_q)
      ST_IDLE: begin
        if (rd_en) begin
          cnt_lo_d = din;
          state_d  = ST_CNT_HI;
        end
      end

      ST_CNT_HI: begin
        if (rd_en) begin
          if (w_n_bad) begin
            error_d = 1'b1;
            state_d = ST_ERROR;
          end else begin
            n_d            = w_n_raw[CW-1:0];
            byte_cnt_d     = '0;
            // The memory is about to be overwritten, so its contents are
            // inconsistent until the terminator is seen.
            config_valid_d = 1'b0;
            state_d        = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (rd_en) begin
          wr_en_d    = 1'b1;
          dout_d     = din;
          wr_addr_d  = byte_cnt_q;
          byte_cnt_d = byte_cnt_q + AW'(1);
          if (byte_cnt_q == w_last) begin
            state_d = ST_MAGIC;
          end
        end
      end

      ST_MAGIC: begin
        if (rd_en) begin
          if (din == MAGIC) begin
            hash_count_d   = n_q;
            config_valid_d = 1'b1;
            state_d        = ST_IDLE;
          end else begin
            error_d = 1'b1;
            state_d = ST_ERROR;
          end
        end
      end

      ST_ERROR: begin
        error_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_lo_q       <= '0;
      n_q            <= '0;
      byte_cnt_q     <= '0;
      dout_q         <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      hash_count_q   <= CW'(1);
      config_valid_q <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_lo_q       <= cnt_lo_d;
      n_q            <= n_d;
      byte_cnt_q     <= byte_cnt_d;
      dout_q         <= dout_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      hash_count_q   <= hash_count_d;
      config_valid_q <= config_valid_d;
      error_q        <= error_d;
    end
  end

  assign dout         = dout_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign hash_count   = hash_count_q;
  assign config_valid = config_valid_q;
  assign error        = error_q;

endmodule : cmp_config_loader
`default_nettype wire

// File: doc/cmp_config_loader.md
# cmp_config_loader

Parses the comparator-configuration packet arriving as a byte stream from the input FIFO and loads the comparator's hash memory and hash count. Sits directly upstream of the comparator and drives its `din`/`wr_en`/`wr_addr`/`hash_count` inputs. It withholds memory writes while a comparison is in progress and flags malformed packets.

## Interface
Parameters:
- `NUM_HASHES`, 512: comparator capacity in 32-bit hashes; power of 2, range 2..4096.
- `HASH_NUM_MSB`, log2(NUM_HASHES)-1: hash index MSB.
- `HASH_COUNT_MSB`, log2(NUM_HASHES): hash count MSB, so the count can hold NUM_HASHES.
- `MAGIC`, 8'hCC: packet terminator byte.

Ports (one clock; reset is asynchronous and active-high):
- `CLK` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `din` in 8: packet byte from the first-word-fall-through FIFO.
- `empty` in 1: FIFO empty; `din` is valid when low.
- `rd_en` out 1: byte consumed this cycle; combinational.
- `cmp_busy` in 1: comparator is running a comparison; no packet bytes are accepted while high.
- `dout` out 8: byte to the comparator memory.
- `wr_en` out 1: comparator memory write strobe.
- `wr_addr` out HASH_NUM_MSB+3: byte address in the comparator memory.
- `hash_count` out HASH_COUNT_MSB+1: number of valid hashes.
- `config_valid` out 1: comparator holds a complete configuration.
- `error` out 1: sticky malformed-packet flag.

## Operation
- Packet format: `cnt_lo`, `cnt_hi` (16-bit little-endian count N), then N×4 hash bytes (little-endian per word), then `MAGIC`.
- States:
  - IDLE: accept a byte, latch it as `cnt_lo`, go to CNT_HI.
  - CNT_HI: accept a byte, form N.
    - If N==0 or N>NUM_HASHES: go to ERROR.
    - Otherwise: clear the byte counter, deassert `config_valid`, go to DATA.
  - DATA: every accepted byte is written at byte counter b, then b increments. After byte N*4-1, go to MAGIC.
  - MAGIC: accept a byte.
    - ==MAGIC: set `hash_count`<=N and `config_valid`<=1, go to IDLE.
    - Otherwise: go to ERROR (`config_valid` stays 0).
  - ERROR: `error`=1, `rd_en`=0, no further bytes consumed. Only `rst` exits.
- `rd_en` = !empty && !cmp_busy && state∈{IDLE,CNT_HI,DATA,MAGIC}.
- `cmp_busy` rising mid-packet pauses consumption at a byte boundary. No byte is lost or duplicated; no write occurs while `cmp_busy` is high.
- Byte counter is HASH_NUM_MSB+3 bits. At N=NUM_HASHES the last address is all-ones, and the counter may wrap to 0 after the final byte; the wrapped value is unused.
- `hash_count` is unchanged from packet start until successful MAGIC. `config_valid`=0 signals the comparator contents are inconsistent.

## Timing
- Reset values: `dout`=0, `wr_en`=0, `wr_addr`=0, `hash_count`=1, `config_valid`=0, `error`=0, state IDLE.
- A byte accepted at edge k appears on `dout`/`wr_addr`/`wr_en` registered after edge k: one cycle of latency. `wr_en` is a single-cycle pulse per byte.
- Throughput: one byte per cycle when the FIFO is non-empty and `cmp_busy` is low.
- `config_valid` falls the cycle after the `cnt_hi` byte is accepted. It rises, together with the `hash_count` update, the cycle after the MAGIC byte is accepted.
- `error` rises the cycle after the offending byte is accepted.
- Reset asserted mid-packet: all outputs return to reset values immediately. Bytes already written stay in the comparator memory; they are invalid because `config_valid`=0.

## Structure
- Shared package/defines: `NUM_HASHES`, `HASH_NUM_MSB`, `HASH_COUNT_MSB`, `CMP_CONFIG_MAGIC`. The comparator uses the same values.
- Single module; no sub-module needed. The byte counter and FSM are local.

## Test plan
- NUM_HASHES=512. Packet 02 00, AA BB CC DD, 11 22 33 44, CC, with a non-empty FIFO and `cmp_busy`=0:
  - 8 writes at addresses 0..7 with data AA,BB,CC,DD,11,22,33,44, one per cycle.
  - `hash_count`=2 and `config_valid`=1 one cycle after CC is accepted.
- Same packet with the terminator 0x55 instead of CC: `error`=1 and `config_valid`=0 after the 0x55 byte; `rd_en` stays 0 afterward; `hash_count` keeps its old value.
- Count 00 00 or 01 02 (513): ERROR after `cnt_hi`; no `wr_en` pulses occur.
- N=512 full packet: final write at `wr_addr`=2047; `hash_count`=512.
- `cmp_busy` held high for 5 cycles after hash byte 3: `rd_en`=0 for those cycles; writes resume at address 3 with no gaps or duplicates.
- `rst` asserted during DATA: outputs return to reset values asynchronously; a following valid packet loads correctly.
